// File: rtl/ss_pkg.sv
// ---------------------------------------------------------------------------
// ss_pkg: shared types and helpers for the up/down seven-segment counter.
//   repeat_state_t : button repeat FSM states
//   SEG_BLANK      : all cathodes off (active-low)
//   SEG_TABLE      : hex glyphs {g,f,e,d,c,b,a}, active-low, indexed by nibble
//   seg_decode     : nibble -> glyph
//   bcd_inc/bcd_dec: single BCD digit step with carry/borrow in and out
// ---------------------------------------------------------------------------
package ss_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        DELAY,
        REPEAT
    } repeat_state_t;

    typedef struct packed {
        logic       carry;
        logic [3:0] digit;
    } bcd_res_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Leftmost entry is nibble F, rightmost is nibble 0.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

    function automatic bcd_res_t bcd_inc(input logic [3:0] d, input logic cin);
        bcd_res_t r;
        r.carry = 1'b0;
        r.digit = d;
        if (cin) begin
            if (d >= 4'd9) begin
                r.carry = 1'b1;
                r.digit = 4'd0;
            end else begin
                r.digit = d + 4'd1;
            end
        end
        return r;
    endfunction

    function automatic bcd_res_t bcd_dec(input logic [3:0] d, input logic bin);
        bcd_res_t r;
        r.carry = 1'b0;
        r.digit = d;
        if (bin) begin
            if (d == 4'd0) begin
                r.carry = 1'b1;
                r.digit = 4'd9;
            end else begin
                r.digit = d - 4'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ss_updown_counter_if.sv
// ---------------------------------------------------------------------------
// ss_updown_counter_if: front-panel signal bundle of the counter.
//   btn_up_i, btn_down_i, mode_i : raw board inputs (driven by master)
//   count_o                      : counter value, nibble k = digit k
//   an                           : active-low anodes, one-hot-low while scanning
//   seg                          : active-low cathodes {g,f,e,d,c,b,a}
//   master = board/driver side, slave = counter side.
// ---------------------------------------------------------------------------
interface ss_updown_counter_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    btn_up_i;
    logic                    btn_down_i;
    logic                    mode_i;
    logic [4*NUM_DIGITS-1:0] count_o;
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              seg;

    modport master (
        output btn_up_i, btn_down_i, mode_i,
        input  count_o, an, seg
    );

    modport slave (
        input  btn_up_i, btn_down_i, mode_i,
        output count_o, an, seg
    );
endinterface

// File: rtl/ss_button_repeat.sv
// ---------------------------------------------------------------------------
// ss_button_repeat: debounce plus hold-to-auto-repeat for one button.
//   clk, reset : clock, asynchronous active-high reset (FSM to IDLE)
//   tick_i     : pacing enable; all state changes happen on tick cycles
//   btn_i      : synchronised button level
//   step_o     : one-cycle step pulse, the cycle after the deciding tick
// First step after DEBOUNCE_TICKS high ticks, second REPEAT_DELAY_TICKS
// ticks later, then one every REPEAT_RATE_TICKS ticks. Release is immediate.
// ---------------------------------------------------------------------------
module ss_button_repeat
    import ss_pkg::*;
#(
    parameter int DEBOUNCE_TICKS     = 3,
    parameter int REPEAT_DELAY_TICKS = 384,
    parameter int REPEAT_RATE_TICKS  = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_i,
    input  logic btn_i,
    output logic step_o
);
    localparam int MAX_A = (DEBOUNCE_TICKS > REPEAT_DELAY_TICKS - 1) ?
                           DEBOUNCE_TICKS : REPEAT_DELAY_TICKS - 1;
    localparam int MAX_T = (MAX_A > REPEAT_RATE_TICKS - 1) ?
                           MAX_A : REPEAT_RATE_TICKS - 1;
    localparam int TW    = $clog2(MAX_T) + 1;

    // tcnt holds the high ticks seen before the current one, so the press is
    // accepted on the tick that brings the total to DEBOUNCE_TICKS.
    localparam logic [TW-1:0] DEB_LAST   = TW'(DEBOUNCE_TICKS - 1);
    localparam logic [TW-1:0] DELAY_LAST = TW'(REPEAT_DELAY_TICKS - 1);
    localparam logic [TW-1:0] RATE_LAST  = TW'(REPEAT_RATE_TICKS - 1);

    repeat_state_t  state_q, state_d;
    logic [TW-1:0]  tcnt_q, tcnt_d;
    logic           step_q, step_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tcnt_q  <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        step_d  = 1'b0;
        if (tick_i) begin
            case (state_q)
                IDLE: begin
                    if (btn_i) begin
                        state_d = DEBOUNCE;
                        tcnt_d  = TW'(1);
                    end
                end
                DEBOUNCE: begin
                    if (!btn_i) begin
                        state_d = IDLE;
                    end else if (tcnt_q >= DEB_LAST) begin
                        step_d  = 1'b1;
                        state_d = DELAY;
                        tcnt_d  = '0;
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
                DELAY: begin
                    if (!btn_i) begin
                        state_d = IDLE;
                    end else if (tcnt_q == DELAY_LAST) begin
                        step_d  = 1'b1;
                        state_d = REPEAT;
                        tcnt_d  = '0;
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
                REPEAT: begin
                    if (!btn_i) begin
                        state_d = IDLE;
                    end else if (tcnt_q == RATE_LAST) begin
                        step_d = 1'b1;
                        tcnt_d = '0;
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    tcnt_d  = '0;
                end
            endcase
        end
    end

    assign step_o = step_q;
endmodule

// File: rtl/ss_clk_en_gen.sv
// ---------------------------------------------------------------------------
// ss_clk_en_gen: free-running divider producing a one-cycle enable pulse
// every 2^DIV_BITS clk cycles.
//   clk, reset : clock, asynchronous active-high reset
//   en_o       : registered one-cycle tick
// ---------------------------------------------------------------------------
module ss_clk_en_gen #(
    parameter int DIV_BITS = 17
) (
    input  logic clk,
    input  logic reset,
    output logic en_o
);
    logic [DIV_BITS-1:0] cnt_q, cnt_d;
    logic                en_q, en_d;

    always_comb begin
        cnt_d = cnt_q + DIV_BITS'(1);
        en_d  = (cnt_q == '1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            en_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            en_q  <= en_d;
        end
    end

    assign en_o = en_q;
endmodule

// File: rtl/ss_sync2.sv
// ---------------------------------------------------------------------------
// ss_sync2: two-flop synchroniser for an asynchronous level input.
//   clk, reset : clock, asynchronous active-high reset (output clears to 0)
//   d_i        : asynchronous input
//   q_o        : synchronised output, two cycles of latency
// ---------------------------------------------------------------------------
module ss_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);
    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/ss_updown_counter.sv
// ---------------------------------------------------------------------------
// ss_updown_counter: up/down press counter with multiplexed 7-seg display.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : front-panel bundle (slave side)
//     btn_up_i/btn_down_i/mode_i in : raw buttons and hex(0)/decimal(1) switch
//     count_o out : NUM_DIGITS-nibble counter value
//     an      out : active-low anodes, one-hot-low while scanning
//     seg     out : active-low cathodes {g,f,e,d,c,b,a}
// A mode change clears the counter and drops any step in that cycle;
// simultaneous up and down steps cancel.
// ---------------------------------------------------------------------------
module ss_updown_counter
    import ss_pkg::*;
#(
    parameter int NUM_DIGITS         = 4,
    parameter int SCAN_DIV_BITS      = 17,
    parameter int DEBOUNCE_TICKS     = 3,
    parameter int REPEAT_DELAY_TICKS = 384,
    parameter int REPEAT_RATE_TICKS  = 64,
    parameter int BLANK_LZ           = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    ss_updown_counter_if.slave    bus
);
    localparam int CW = 4 * NUM_DIGITS;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic up_s, down_s, mode_s;
    logic clk_en;
    logic up_step, down_step;

    logic                  mode_prev_q, mode_prev_d;
    logic [CW-1:0]         count_q, count_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;

    logic                  carry;
    bcd_res_t              res;
    logic [3:0]            nib;
    logic                  upper_zero;

    ss_sync2 u_sync_up (
        .clk   (clk),
        .reset (reset),
        .d_i   (bus.btn_up_i),
        .q_o   (up_s)
    );

    ss_sync2 u_sync_down (
        .clk   (clk),
        .reset (reset),
        .d_i   (bus.btn_down_i),
        .q_o   (down_s)
    );

    ss_sync2 u_sync_mode (
        .clk   (clk),
        .reset (reset),
        .d_i   (bus.mode_i),
        .q_o   (mode_s)
    );

    ss_clk_en_gen #(
        .DIV_BITS (SCAN_DIV_BITS)
    ) u_clk_en (
        .clk   (clk),
        .reset (reset),
        .en_o  (clk_en)
    );

    ss_button_repeat #(
        .DEBOUNCE_TICKS     (DEBOUNCE_TICKS),
        .REPEAT_DELAY_TICKS (REPEAT_DELAY_TICKS),
        .REPEAT_RATE_TICKS  (REPEAT_RATE_TICKS)
    ) u_rep_up (
        .clk    (clk),
        .reset  (reset),
        .tick_i (clk_en),
        .btn_i  (up_s),
        .step_o (up_step)
    );

    ss_button_repeat #(
        .DEBOUNCE_TICKS     (DEBOUNCE_TICKS),
        .REPEAT_DELAY_TICKS (REPEAT_DELAY_TICKS),
        .REPEAT_RATE_TICKS  (REPEAT_RATE_TICKS)
    ) u_rep_down (
        .clk    (clk),
        .reset  (reset),
        .tick_i (clk_en),
        .btn_i  (down_s),
        .step_o (down_step)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_prev_q <= 1'b0;
            count_q     <= '0;
            idx_q       <= '0;
            an_q        <= '1;
            seg_q       <= SEG_BLANK;
        end else begin
            mode_prev_q <= mode_prev_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    // Counter update
    always_comb begin
        mode_prev_d = mode_s;
        count_d     = count_q;
        carry       = 1'b0;
        res         = '0;
        if (mode_s != mode_prev_q) begin
            count_d = '0;
        end else if (up_step != down_step) begin
            if (!mode_s) begin
                count_d = up_step ? count_q + CW'(1) : count_q - CW'(1);
            end else begin
                // Carry/borrow ripples from digit 0 upward; a carry out of
                // the top digit is dropped, giving wrap modulo 10^NUM_DIGITS.
                carry = 1'b1;
                for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                    res = up_step ? bcd_inc(count_q[4*k +: 4], carry)
                                  : bcd_dec(count_q[4*k +: 4], carry);
                    count_d[4*k +: 4] = res.digit;
                    carry             = res.carry;
                end
            end
        end
    end

    // Display scan: index, anode and glyph registered together on each tick
    always_comb begin
        idx_d      = idx_q;
        an_d       = an_q;
        seg_d      = seg_q;
        nib        = '0;
        upper_zero = 1'b0;
        if (clk_en) begin
            idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
            for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                if (IW'(k) == idx_d) begin
                    nib        = count_q[4*k +: 4];
                    upper_zero = (k != 0) && ((count_q >> (4*k)) == '0);
                end
            end
            an_d  = ~(NUM_DIGITS'(1) << idx_d);
            seg_d = ((BLANK_LZ != 0) && upper_zero) ? SEG_BLANK : seg_decode(nib);
        end
    end

    assign bus.count_o = count_q;
    assign bus.an      = an_q;
    assign bus.seg     = seg_q;
endmodule
